uart_pkt_deframer: RTL and testbench
====================================

UART_PKT_DEFRAMER -- requirements
Module: uart_pkt_deframer

Interface
REQ-001 Parameter MAX_LEN, default 16, maximum payload bytes per packet (1..255).
REQ-002 Parameter SYNC_BYTE, default 8'hA5, start-of-packet marker.
REQ-003 Parameter TIMEOUT_CYC, default 52083, maximum clk cycles between bytes inside a packet (~10 bit times at 9600 baud, 50 MHz).
REQ-004 Clocking: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  system clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 uart_rx_valid  in  1  one-cycle strobe, a received byte is present on uart_rx_data.
REQ-008 uart_rx_data  in  8  received byte, sampled only when uart_rx_valid=1.
REQ-009 uart_rx_break  in  1  line break detected by the receiver.
REQ-010 pkt_valid  out  1  pkt_data holds a payload byte of a checksum-verified packet.
REQ-011 pkt_ready  in  1  downstream accepts the byte; a transfer occurs when pkt_valid and pkt_ready are both 1.
REQ-012 pkt_data  out  8  payload byte.
REQ-013 pkt_last  out  1  marks the final payload byte of the packet.
REQ-014 pkt_len  out  8  LEN of the packet being drained; stable while pkt_valid=1.
REQ-015 err_csum, err_len, err_timeout, err_overrun  out  1 each  one-cycle error pulses.
REQ-016 busy  out  1  high in any state other than HUNT.

Function
REQ-017 Frame format: SYNC_BYTE, LEN, LEN payload bytes, CSUM. Valid when (LEN + sum of payload + CSUM) mod 256 = 0.
REQ-018 States: HUNT, LEN, PAYLOAD, CSUM, DRAIN. Input bytes are consumed only on uart_rx_valid.
REQ-019 HUNT: a byte equal to SYNC_BYTE moves to LEN; all other bytes are ignored silently.
REQ-020 LEN: LEN=0 or LEN>MAX_LEN pulses err_len and returns to HUNT; otherwise stores LEN, sets the running sum to LEN, and moves to PAYLOAD.
REQ-021 PAYLOAD: writes each byte to buffer[index], adds it to the running sum (8-bit wrap), and increments index; after the LEN-th byte, moves to CSUM.
REQ-022 A payload byte equal to SYNC_BYTE is treated as data; there is no escaping or resync inside a frame.
REQ-023 CSUM: if the 8-bit sum plus CSUM = 0, moves to DRAIN; otherwise pulses err_csum and returns to HUNT, discarding the buffer.
REQ-024 The timeout counter clears on every accepted byte and counts while in LEN, PAYLOAD or CSUM.
REQ-025 When the timeout counter reaches TIMEOUT_CYC, the block pulses err_timeout and returns to HUNT.
REQ-026 pkt_valid rises in the cycle after the CSUM byte is accepted.
REQ-027 DRAIN presents buffer[0..LEN-1] in order, advancing one byte per transfer, with pkt_last=1 on byte LEN-1.
REQ-028 The transfer of the last byte returns the FSM to HUNT, with pkt_valid=0 in the next cycle.
REQ-029 pkt_data, pkt_last and pkt_len hold stable while pkt_valid=1 and pkt_ready=0.
REQ-030 A byte arriving in DRAIN is dropped with an err_overrun pulse; the drain continues unaffected.
REQ-031 uart_rx_break=1 in LEN, PAYLOAD or CSUM aborts to HUNT the next cycle, with no error pulse and no output. In DRAIN it has no effect.
REQ-032 If uart_rx_valid and uart_rx_break are asserted in the same cycle, break wins and the byte is discarded.
REQ-033 No pkt_valid is ever raised for a partial or failed frame.

Reset
REQ-034 Reset forces state HUNT, clears the index, running sum and timeout counter, and drives pkt_valid, pkt_last, all err_* and busy to 0.
REQ-035 After reset, pkt_data and pkt_len are 0.
REQ-036 Reset asserted mid-frame or mid-drain abandons the packet; buffer contents need not be cleared.

Structure
REQ-037 A shared package uart_pkg holds the state enumeration, the default SYNC_BYTE and the CSUM rule constant.
REQ-038 The payload buffer is one sub-module, pkt_buf_ram: MAX_LEN x 8, one synchronous write port, one read port.
REQ-039 The pkt_buf_ram read is prefetched so that REQ-026 latency holds.

Verification
REQ-040 Valid frame: A5 02 11 22 CB, pkt_ready=1 -> pkt_data 11 then 22, pkt_last on 22, pkt_len=2, no error pulses.
REQ-041 Backpressure: A5 03 01 02 03 F7, pkt_ready toggling 1/0 -> all three bytes delivered in order, outputs stable while stalled.
REQ-042 Bad checksum: A5 02 11 22 CC -> one err_csum pulse, no pkt_valid; the following valid frame is still delivered.
REQ-043 Length errors: A5 00 and A5 11 (MAX_LEN=16) -> one err_len pulse each, state HUNT.
REQ-044 Timeout: A5 02 11, then idle for TIMEOUT_CYC cycles -> one err_timeout pulse, busy=0.
REQ-045 Abort and overrun: break during PAYLOAD -> HUNT, no output; bytes sent during DRAIN with pkt_ready=0 -> err_overrun per byte, drained payload intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART packet deframer: FSM state encodings,
// default start marker and the checksum rule.
package uart_pkg;

  localparam logic [2:0] ST_HUNT    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_PAYLOAD = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_DRAIN   = 3'd4;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // A frame is good when LEN + payload + CSUM wraps to this value.
  localparam logic [7:0] CSUM_GOOD = 8'h00;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/pkt_buf_ram.sv
// Payload buffer: DEPTH x 8 memory, one synchronous write port and one
// registered read port so it maps onto block RAM.
module pkt_buf_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_pkt_deframer.sv
// Deframes SYNC/LEN/payload/CSUM packets from a UART byte stream, verifies the
// checksum and drains the buffered payload over a valid/ready interface.
module uart_pkt_deframer
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_BYTE_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 52083
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rx_valid,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_break,
  output logic       pkt_valid,
  input  logic       pkt_ready,
  output logic [7:0] pkt_data,
  output logic       pkt_last,
  output logic [7:0] pkt_len,
  output logic       err_csum,
  output logic       err_len,
  output logic       err_timeout,
  output logic       err_overrun,
  output logic       busy
);

  localparam int unsigned   AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned   TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_csum_q, err_csum_d;
  logic          err_len_q, err_len_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_overrun_q, err_overrun_d;

  logic          wr_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          last_byte;

  pkt_buf_ram #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (idx_q[AW-1:0]),
    .wr_data (uart_rx_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign last_byte = (idx_q == (len_q - 8'd1));

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    sum_d         = sum_q;
    idx_d         = idx_q;
    tmo_d         = tmo_q;
    err_csum_d    = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    wr_en         = 1'b0;
    // Address 0 is read while waiting for CSUM so byte 0 is ready on DRAIN entry.
    rd_addr       = '0;

    case (state_q)
      ST_HUNT: begin
        tmo_d = '0;
        idx_d = '0;
        if (uart_rx_valid && !uart_rx_break && (uart_rx_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end

      ST_LEN, ST_PAYLOAD, ST_CSUM: begin
        if (uart_rx_break) begin
          // Abort silently; a byte in the same cycle is discarded.
          state_d = ST_HUNT;
          tmo_d   = '0;
        end else if (uart_rx_valid) begin
          tmo_d = '0;
          case (state_q)
            ST_LEN: begin
              if ((uart_rx_data == 8'd0) || (uart_rx_data > MAX_LEN_B)) begin
                err_len_d = 1'b1;
                state_d   = ST_HUNT;
              end else begin
                len_d   = uart_rx_data;
                sum_d   = uart_rx_data;
                idx_d   = '0;
                state_d = ST_PAYLOAD;
              end
            end
            ST_PAYLOAD: begin
              wr_en = 1'b1;
              sum_d = csum_add(sum_q, uart_rx_data);
              idx_d = idx_q + 8'd1;
              if (last_byte) begin
                state_d = ST_CSUM;
              end
            end
            default: begin
              if (csum_add(sum_q, uart_rx_data) == CSUM_GOOD) begin
                idx_d   = '0;
                state_d = ST_DRAIN;
              end else begin
                err_csum_d = 1'b1;
                state_d    = ST_HUNT;
              end
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          err_timeout_d = 1'b1;
          tmo_d         = '0;
          state_d       = ST_HUNT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      ST_DRAIN: begin
        tmo_d = '0;
        if (uart_rx_valid) begin
          err_overrun_d = 1'b1;
        end
        // Prefetch the next byte on a transfer, otherwise re-read the current one.
        if (pkt_ready) begin
          rd_addr = idx_q[AW-1:0] + AW'(1);
          if (last_byte) begin
            idx_d   = '0;
            state_d = ST_HUNT;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          rd_addr = idx_q[AW-1:0];
        end
      end

      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_HUNT;
      len_q         <= '0;
      sum_q         <= '0;
      idx_q         <= '0;
      tmo_q         <= '0;
      err_csum_q    <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      sum_q         <= sum_d;
      idx_q         <= idx_d;
      tmo_q         <= tmo_d;
      err_csum_q    <= err_csum_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign pkt_valid   = (state_q == ST_DRAIN);
  assign pkt_data    = pkt_valid ? rd_data : 8'h00;
  assign pkt_last    = pkt_valid && last_byte;
  assign pkt_len     = len_q;
  assign busy        = (state_q != ST_HUNT);
  assign err_csum    = err_csum_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

endmodule

// File: tb/tb_uart_pkt_deframer.sv
// Directed bench for uart_pkt_deframer: one task per scenario, expected
// values hand-computed from the frame format.
module tb_uart_pkt_deframer;

  localparam int unsigned T = 64;

  logic       clk;
  logic       reset;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_break;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [7:0] pkt_data;
  logic       pkt_last;
  logic [7:0] pkt_len;
  logic       err_csum, err_len, err_timeout, err_overrun;
  logic       busy;

  int vecs;
  int miscmp;

  int n_csum, n_len, n_tmo, n_ovr;
  logic [8:0] rx_q[$];
  logic [7:0] rxlen_q[$];

  uart_pkt_deframer #(
    .MAX_LEN     (16),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (T)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_break (uart_rx_break),
    .pkt_valid     (pkt_valid),
    .pkt_ready     (pkt_ready),
    .pkt_data      (pkt_data),
    .pkt_last      (pkt_last),
    .pkt_len       (pkt_len),
    .err_csum      (err_csum),
    .err_len       (err_len),
    .err_timeout   (err_timeout),
    .err_overrun   (err_overrun),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfers and error pulses are observed on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (err_csum)    n_csum++;
      if (err_len)     n_len++;
      if (err_timeout) n_tmo++;
      if (err_overrun) n_ovr++;
      if (pkt_valid && pkt_ready) begin
        rx_q.push_back({pkt_last, pkt_data});
        rxlen_q.push_back(pkt_len);
        $display("xfer data=%02h last=%0b len=%0d", pkt_data, pkt_last, pkt_len);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_valid = 1'b1;
    uart_rx_data  = b;
    step();
    uart_rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      step();
      n++;
    end
    vecs++;
    if (busy !== 1'b0) begin
      miscmp++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, expected 0", busy, budget);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'hA5;
    repeat (3) step();
    uart_rx_valid = 1'b0;
    reset = 1'b0;
    step();
    vecs++; if (pkt_valid !== 1'b0) begin miscmp++; $display("FAIL reset_valid: got %b expected 0", pkt_valid); end
    vecs++; if (pkt_last !== 1'b0) begin miscmp++; $display("FAIL reset_last: got %b expected 0", pkt_last); end
    vecs++; if (pkt_data !== 8'h00) begin miscmp++; $display("FAIL reset_data: got %h expected 00", pkt_data); end
    vecs++; if (pkt_len !== 8'h00) begin miscmp++; $display("FAIL reset_len: got %h expected 00", pkt_len); end
    vecs++; if (busy !== 1'b0) begin miscmp++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vecs++;
    if ({err_csum, err_len, err_timeout, err_overrun} !== 4'b0000) begin
      miscmp++;
      $display("FAIL reset_err: got %b expected 0000", {err_csum, err_len, err_timeout, err_overrun});
    end
  endtask

  task automatic test_valid_frame();
    int base, e0;
    base = rx_q.size();
    e0 = n_csum + n_len + n_tmo + n_ovr;
    pkt_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'hCB);
    vecs++; if (pkt_valid !== 1'b1) begin miscmp++; $display("FAIL valid_latency: pkt_valid=%b expected 1", pkt_valid); end
    vecs++; if (pkt_data !== 8'h11) begin miscmp++; $display("FAIL valid_first: got %h expected 11", pkt_data); end
    vecs++; if (pkt_len !== 8'd2) begin miscmp++; $display("FAIL valid_len: got %0d expected 2", pkt_len); end
    wait_idle(10);
    vecs++; if (rx_q.size() - base !== 2) begin miscmp++; $display("FAIL valid_count: got %0d expected 2", rx_q.size() - base); end
    vecs++; if (rx_q[base] !== 9'h011) begin miscmp++; $display("FAIL valid_b0: got %h expected 011", rx_q[base]); end
    vecs++; if (rx_q[base+1] !== 9'h122) begin miscmp++; $display("FAIL valid_b1: got %h expected 122", rx_q[base+1]); end
    vecs++; if (n_csum + n_len + n_tmo + n_ovr - e0 !== 0) begin miscmp++; $display("FAIL valid_errs: got %0d expected 0", n_csum + n_len + n_tmo + n_ovr - e0); end
    vecs++; if (pkt_valid !== 1'b0) begin miscmp++; $display("FAIL valid_after: pkt_valid=%b expected 0", pkt_valid); end
  endtask

  task automatic test_backpressure();
    int base;
    logic [7:0] d0, n0;
    logic l0, v0, r0;
    base = rx_q.size();
    pkt_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'hF7);
    for (int c = 0; c < 12; c++) begin
      d0 = pkt_data; l0 = pkt_last; n0 = pkt_len; v0 = pkt_valid;
      r0 = (c % 2 == 1);
      pkt_ready = r0;
      step();
      if (v0 && !r0) begin
        vecs++;
        if ({pkt_valid, pkt_data, pkt_last, pkt_len} !== {1'b1, d0, l0, n0}) begin
          miscmp++;
          $display("FAIL bp_stable: got v=%b d=%h l=%b n=%0d expected v=1 d=%h l=%b n=%0d",
                   pkt_valid, pkt_data, pkt_last, pkt_len, d0, l0, n0);
        end
      end
    end
    pkt_ready = 1'b1;
    wait_idle(10);
    vecs++; if (rx_q.size() - base !== 3) begin miscmp++; $display("FAIL bp_count: got %0d expected 3", rx_q.size() - base); end
    vecs++; if (rx_q[base] !== 9'h001) begin miscmp++; $display("FAIL bp_b0: got %h expected 001", rx_q[base]); end
    vecs++; if (rx_q[base+1] !== 9'h002) begin miscmp++; $display("FAIL bp_b1: got %h expected 002", rx_q[base+1]); end
    vecs++; if (rx_q[base+2] !== 9'h103) begin miscmp++; $display("FAIL bp_b2: got %h expected 103", rx_q[base+2]); end
    vecs++; if (rxlen_q[base+2] !== 8'd3) begin miscmp++; $display("FAIL bp_len: got %0d expected 3", rxlen_q[base+2]); end
  endtask

  task automatic test_bad_csum();
    int base, c0;
    base = rx_q.size();
    c0 = n_csum;
    pkt_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'hCC);
    vecs++; if (err_csum !== 1'b1) begin miscmp++; $display("FAIL csum_pulse: got %b expected 1", err_csum); end
    vecs++; if (pkt_valid !== 1'b0) begin miscmp++; $display("FAIL csum_novalid: got %b expected 0", pkt_valid); end
    // Follow-up frame whose payload equals the sync byte.
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hA5); send_byte(8'h5A);
    wait_idle(10);
    vecs++; if (n_csum - c0 !== 1) begin miscmp++; $display("FAIL csum_count: got %0d expected 1", n_csum - c0); end
    vecs++; if (rx_q.size() - base !== 1) begin miscmp++; $display("FAIL csum_next_count: got %0d expected 1", rx_q.size() - base); end
    vecs++; if (rx_q[base] !== 9'h1A5) begin miscmp++; $display("FAIL csum_next_b0: got %h expected 1A5", rx_q[base]); end
  endtask

  task automatic test_len_err();
    int l0;
    l0 = n_len;
    send_byte(8'hA5); send_byte(8'h00);
    vecs++; if ({err_len, busy} !== 2'b10) begin miscmp++; $display("FAIL len_zero: got err_len,busy=%b expected 10", {err_len, busy}); end
    send_byte(8'hA5); send_byte(8'h11);
    vecs++; if ({err_len, busy} !== 2'b10) begin miscmp++; $display("FAIL len_big: got err_len,busy=%b expected 10", {err_len, busy}); end
    step();
    vecs++; if (n_len - l0 !== 2) begin miscmp++; $display("FAIL len_count: got %0d expected 2", n_len - l0); end
  endtask

  task automatic test_max_len();
    int base;
    base = rx_q.size();
    pkt_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 1; i <= 16; i++) send_byte(8'(i));
    send_byte(8'h68);
    wait_idle(30);
    vecs++; if (rx_q.size() - base !== 16) begin miscmp++; $display("FAIL max_count: got %0d expected 16", rx_q.size() - base); end
    for (int i = 0; i < 16; i++) begin
      vecs++;
      if (rx_q[base+i] !== {(i == 15), 8'(i + 1)}) begin
        miscmp++;
        $display("FAIL max_b%0d: got %h expected %h", i, rx_q[base+i], {(i == 15), 8'(i + 1)});
      end
    end
  endtask

  task automatic test_timeout();
    int t0;
    t0 = n_tmo;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    repeat (T - 1) step();
    vecs++; if ({err_timeout, busy} !== 2'b01) begin miscmp++; $display("FAIL tmo_early: got err_timeout,busy=%b expected 01", {err_timeout, busy}); end
    step();
    vecs++; if ({err_timeout, busy} !== 2'b10) begin miscmp++; $display("FAIL tmo_fire: got err_timeout,busy=%b expected 10", {err_timeout, busy}); end
    step();
    vecs++; if (n_tmo - t0 !== 1) begin miscmp++; $display("FAIL tmo_count: got %0d expected 1", n_tmo - t0); end
  endtask

  task automatic test_break();
    int base, e0;
    base = rx_q.size();
    e0 = n_csum + n_len + n_tmo + n_ovr;
    pkt_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h01);
    uart_rx_break = 1'b1;
    uart_rx_valid = 1'b1;
    uart_rx_data  = 8'h02;
    step();
    uart_rx_break = 1'b0;
    uart_rx_valid = 1'b0;
    vecs++; if (busy !== 1'b0) begin miscmp++; $display("FAIL brk_hunt: busy=%b expected 0", busy); end
    send_byte(8'h02); send_byte(8'h03); send_byte(8'hF7);
    repeat (3) step();
    vecs++; if (rx_q.size() - base !== 0) begin miscmp++; $display("FAIL brk_nodata: got %0d bytes expected 0", rx_q.size() - base); end
    vecs++; if (n_csum + n_len + n_tmo + n_ovr - e0 !== 0) begin miscmp++; $display("FAIL brk_errs: got %0d expected 0", n_csum + n_len + n_tmo + n_ovr - e0); end
  endtask

  task automatic test_overrun();
    int base, o0;
    base = rx_q.size();
    o0 = n_ovr;
    pkt_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22); send_byte(8'hCB);
    send_byte(8'hFF);
    vecs++; if ({err_overrun, pkt_data} !== 9'h111) begin miscmp++; $display("FAIL ovr_pulse: got ovr,data=%h expected 111", {err_overrun, pkt_data}); end
    send_byte(8'hA5);
    send_byte(8'h02);
    pkt_ready = 1'b1;
    wait_idle(10);
    vecs++; if (n_ovr - o0 !== 3) begin miscmp++; $display("FAIL ovr_count: got %0d expected 3", n_ovr - o0); end
    vecs++; if (rx_q.size() - base !== 2) begin miscmp++; $display("FAIL ovr_bytes: got %0d expected 2", rx_q.size() - base); end
    vecs++; if (rx_q[base] !== 9'h011) begin miscmp++; $display("FAIL ovr_b0: got %h expected 011", rx_q[base]); end
    vecs++; if (rx_q[base+1] !== 9'h122) begin miscmp++; $display("FAIL ovr_b1: got %h expected 122", rx_q[base+1]); end
  endtask

  task automatic test_reset_mid_drain();
    pkt_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h33); send_byte(8'hCC);
    vecs++; if (pkt_valid !== 1'b1) begin miscmp++; $display("FAIL rst_mid_pre: pkt_valid=%b expected 1", pkt_valid); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    vecs++;
    if ({pkt_valid, busy, pkt_data, pkt_len} !== 18'h0) begin
      miscmp++;
      $display("FAIL rst_mid: got v=%b busy=%b d=%h len=%h expected all 0", pkt_valid, busy, pkt_data, pkt_len);
    end
    pkt_ready = 1'b1;
  endtask

  initial begin
    vecs = 0; miscmp = 0;
    n_csum = 0; n_len = 0; n_tmo = 0; n_ovr = 0;
    reset = 1'b1;
    uart_rx_valid = 1'b0;
    uart_rx_data  = 8'h00;
    uart_rx_break = 1'b0;
    pkt_ready     = 1'b0;
    #1;
    test_reset();
    test_valid_frame();
    test_backpressure();
    test_bad_csum();
    test_len_err();
    test_max_len();
    test_timeout();
    test_break();
    test_overrun();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
    $finish;
  end

endmodule
